// File: rtl/barcode_rx.sv
// Barcode receiver: calibrates bit timing from the start bit, then samples eight
// data cells MSB first and publishes legal station IDs with a sticky valid flag.
module barcode_rx #(
  parameter int CNT_W = 22
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       BC,
  input  logic       clr_ID_vld,
  output logic [7:0] ID,
  output logic       ID_vld
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_FALL = 3'd2,
    WAIT_SAMP = 3'd3,
    CHECK     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] TMR_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             bc_s1_q, bc_s2_q, bc_s3_q;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] dur_q, dur_d;
  logic [7:0]       shft_q, shft_d;
  logic [2:0]       bcnt_q, bcnt_d;
  logic [7:0]       id_q, id_d;
  logic             vld_q, vld_d;

  logic fall, rise, tmr_sat;

  // bc_s2_q is the synchronized line; bc_s3_q is its one-cycle-old copy.
  assign fall    = bc_s3_q & ~bc_s2_q;
  assign rise    = ~bc_s3_q & bc_s2_q;
  assign tmr_sat = &tmr_q;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    dur_d   = dur_q;
    shft_d  = shft_q;
    bcnt_d  = bcnt_q;
    id_d    = id_q;
    vld_d   = clr_ID_vld ? 1'b0 : vld_q;
    case (state_q)
      IDLE: begin
        if (fall) begin
          tmr_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (rise) begin
          dur_d   = tmr_q;
          tmr_d   = '0;
          bcnt_d  = 3'd0;
          state_d = WAIT_FALL;
        end else if (tmr_sat) begin
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + TMR_ONE;
        end
      end
      WAIT_FALL: begin
        if (fall) begin
          tmr_d   = '0;
          state_d = WAIT_SAMP;
        end else if (tmr_sat) begin
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + TMR_ONE;
        end
      end
      WAIT_SAMP: begin
        // Falling edges before the sample point are deliberately ignored.
        if (tmr_q == dur_q) begin
          shft_d  = {shft_q[6:0], bc_s2_q};
          bcnt_d  = bcnt_q + 3'd1;
          tmr_d   = '0;
          state_d = (bcnt_q == 3'd7) ? CHECK : WAIT_FALL;
        end else if (tmr_sat) begin
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + TMR_ONE;
        end
      end
      CHECK: begin
        if (shft_q[7:6] == 2'b00) begin
          id_d  = shft_q;
          vld_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bc_s1_q <= 1'b1;
      bc_s2_q <= 1'b1;
      bc_s3_q <= 1'b1;
      state_q <= IDLE;
      tmr_q   <= '0;
      dur_q   <= '0;
      shft_q  <= 8'h00;
      bcnt_q  <= 3'd0;
      id_q    <= 8'h00;
      vld_q   <= 1'b0;
    end else begin
      bc_s1_q <= BC;
      bc_s2_q <= bc_s1_q;
      bc_s3_q <= bc_s2_q;
      state_q <= state_d;
      tmr_q   <= tmr_d;
      dur_q   <= dur_d;
      shft_q  <= shft_d;
      bcnt_q  <= bcnt_d;
      id_q    <= id_d;
      vld_q   <= vld_d;
    end
  end

  assign ID     = id_q;
  assign ID_vld = vld_q;

endmodule

// File: tb/tb_barcode_rx.sv
// Bench for barcode_rx: drives encoded frames on BC, queues the IDs expected to
// be published and compares them as the receiver announces new IDs.
module tb_barcode_rx;

  // Narrow timer so the stuck-line abort fits a short run.
  localparam int CNT_W = 13;

  logic       clk;
  logic       rst_n;
  logic       BC;
  logic       clr_ID_vld;
  logic [7:0] ID;
  logic       ID_vld;

  logic [7:0] exp_q[$];
  int         n_chk;
  int         n_fail;
  int         cyc;
  int         bit0_cyc;
  int         lat_limit;
  int         clr_delay;

  barcode_rx #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .BC         (BC),
    .clr_ID_vld (clr_ID_vld),
    .ID         (ID),
    .ID_vld     (ID_vld)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Driver tasks
  task automatic hold(input logic v, input int n);
    BC = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] id, input int p, input bit clr_at_check);
    if (id[7:6] == 2'b00) exp_q.push_back(id);
    lat_limit = p / 2 + 10;
    hold(1'b0, p / 2);
    hold(1'b1, p / 2);
    for (int i = 7; i >= 0; i--) begin
      if (i == 0) begin
        bit0_cyc = cyc;
        if (clr_at_check) begin
          clr_delay = p / 2 + 3;
          fork
            begin
              repeat (clr_delay) @(posedge clk);
              #1 clr_ID_vld = 1'b1;
              @(posedge clk);
              #1 clr_ID_vld = 1'b0;
            end
          join_none
        end
      end
      hold(1'b0, id[i] ? p / 4 : 3 * p / 4);
      hold(1'b1, id[i] ? 3 * p / 4 : p / 4);
    end
  endtask

  task automatic pulse_clr();
    clr_ID_vld = 1'b1;
    @(posedge clk);
    #1;
    clr_ID_vld = 1'b0;
    chk("clr_vld", ID_vld, 1'b0);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", exp_q.size(), 0);
  endtask

  // Scoreboard: a new publication is a rise of ID_vld or a change of ID while set.
  initial begin
    logic [7:0] prev_id;
    logic       prev_vld;
    logic [7:0] exp;
    prev_id  = 8'h00;
    prev_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_id  = 8'h00;
        prev_vld = 1'b0;
      end else begin
        if (ID_vld && (!prev_vld || ID != prev_id)) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out", {24'h0, ID}, 32'hffff_ffff);
          end else begin
            exp = exp_q.pop_front();
            chk("id", ID, exp);
            chk("latency_ok", (cyc - bit0_cyc) <= lat_limit, 1'b1);
          end
        end
        prev_id  = ID;
        prev_vld = ID_vld;
      end
    end
  end

  initial begin
    #(20 * 200000);
    $display("FAIL watchdog: got timeout expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    bit0_cyc   = 0;
    lat_limit  = 0;
    clr_delay  = 0;
    BC         = 1'b1;
    clr_ID_vld = 1'b0;
    rst_n      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_id", ID, 8'h00);
    chk("rst_vld", ID_vld, 1'b0);
    rst_n = 1'b1;
    hold(1'b1, 4);

    // Long period, legal ID, then ID stays put.
    send_frame(8'h25, 32'h1000, 1'b0);
    wait_drain(20);
    hold(1'b1, 50);
    chk("id_stable", ID, 8'h25);
    chk("vld_25", ID_vld, 1'b1);

    // Illegal ID is dropped; then clear.
    send_frame(8'hC5, 32'h100, 1'b0);
    hold(1'b1, 20);
    chk("illegal_id", ID, 8'h25);
    chk("illegal_vld", ID_vld, 1'b1);
    pulse_clr();

    // Short period, back-to-back frames.
    send_frame(8'h3F, 32'h40, 1'b0);
    send_frame(8'h00, 32'h40, 1'b0);
    wait_drain(20);
    chk("b2b_id", ID, 8'h00);
    chk("b2b_vld", ID_vld, 1'b1);

    // Clear coinciding with the CHECK cycle: set wins.
    pulse_clr();
    hold(1'b1, 4);
    send_frame(8'h2A, 32'h40, 1'b1);
    wait_drain(20);
    chk("set_wins_vld", ID_vld, 1'b1);
    chk("set_wins_id", ID, 8'h2A);

    // Reset during bit 4 of a frame.
    hold(1'b0, 32'h20);
    hold(1'b1, 32'h20);
    for (int i = 0; i < 3; i++) begin
      hold(1'b0, 16);
      hold(1'b1, 48);
    end
    hold(1'b0, 8);
    rst_n = 1'b0;
    #1;
    chk("midrst_id", ID, 8'h00);
    chk("midrst_vld", ID_vld, 1'b0);
    hold(1'b1, 5);
    rst_n = 1'b1;
    hold(1'b1, 4);
    send_frame(8'h12, 32'h40, 1'b0);
    wait_drain(20);
    chk("post_rst_id", ID, 8'h12);

    // Stuck-low line saturates the timer and aborts.
    pulse_clr();
    hold(1'b0, (1 << CNT_W) + 100);
    chk("stuck_vld", ID_vld, 1'b0);
    chk("stuck_id", ID, 8'h12);
    hold(1'b1, 10);
    send_frame(8'h07, 32'h40, 1'b0);
    wait_drain(20);
    chk("post_stuck_vld", ID_vld, 1'b1);

    // A randomized legal frame at a random period.
    begin
      logic [7:0] rid;
      int         rp;
      rid = 8'($urandom_range(0, 63));
      if (rid == 8'h07) rid = 8'h08;
      rp  = 16 * int'($urandom_range(1, 8));
      hold(1'b1, 4);
      send_frame(rid, rp, 1'b0);
      wait_drain(20);
      chk("rand_id", ID, rid);
    end

    hold(1'b1, 10);
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
